// File: rtl/signed_divider_nbym.sv
// Sequential signed 2N-by-N restoring divider with St/Done start-and-hold handshake.
// Optional macro DIV_EUCLID_EN selects Euclidean (non-negative remainder) results.
module signed_divider_nbym #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           St,
   input  logic [2*N-1:0] Dvd,
   input  logic [N-1:0]   Dvs,
   output logic           Busy,
   output logic           Done,
   output logic           V,
   output logic [N-1:0]   Quo,
   output logic [N-1:0]   Rem
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_DIV   = 3'd2,
      S_FIX   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic signed [N+1:0] QMAX = {3'b000, {(N-1){1'b1}}};
   localparam logic signed [N+1:0] QMIN = {3'b111, {(N-1){1'b0}}};
   localparam logic signed [N+1:0] ONE  = {{(N+1){1'b0}}, 1'b1};

   state_t state, next_state;

   logic [N:0]    prem;     // partial remainder, one guard bit
   logic [N-1:0]  qsr;      // low dividend bits shifting out, quotient bits shifting in
   logic [N-1:0]  dvs_mag;
   logic          sd, sv, ovf;
   logic [CW-1:0] cnt;

   logic [2*N-1:0]        dvd_abs;
   logic [N-1:0]          dvs_abs;
   logic                  check_ovf;
   logic [N:0]            shifted;
   logic [N+1:0]          trial;
   logic                  trial_neg;
   logic [N-1:0]          r_mag;
   logic signed [N+1:0]   q_val, q_fin;
   logic [N-1:0]          r_fin;
   logic                  fix_ovf;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      dvd_abs   = Dvd[2*N-1] ? (~Dvd + 1'b1) : Dvd;
      dvs_abs   = Dvs[N-1]   ? (~Dvs + 1'b1) : Dvs;
      check_ovf = (dvs_mag == '0) || (prem[N-1:0] >= dvs_mag);

      shifted   = {prem[N-1:0], qsr[N-1]};
      trial     = {1'b0, shifted} - {2'b00, dvs_mag};
      trial_neg = trial[N+1];

      r_mag = prem[N-1:0];
      q_val = (sd ^ sv) ? -$signed({2'b00, qsr}) : $signed({2'b00, qsr});
      q_fin = q_val;
      r_fin = sd ? (~r_mag + 1'b1) : r_mag;
`ifdef DIV_EUCLID_EN
      // Negative truncated remainder: move one divisor step toward -inf of Quo*sign(Dvs).
      if (sd && (r_mag != '0)) begin
         r_fin = dvs_mag - r_mag;
         q_fin = sv ? (q_val + ONE) : (q_val - ONE);
      end
`endif
      fix_ovf = ovf || (q_fin > QMAX) || (q_fin < QMIN);
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (St) next_state = S_CHECK;
         // Overflow also passes through FIX so that both paths register results there.
         S_CHECK: next_state = check_ovf ? S_FIX : S_DIV;
         S_DIV:   if (cnt == CW'(N - 1)) next_state = S_FIX;
         S_FIX:   next_state = S_DONE;
         S_DONE:  if (!St) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         V       <= 1'b0;
         Quo     <= '0;
         Rem     <= '0;
         prem    <= '0;
         qsr     <= '0;
         dvs_mag <= '0;
         sd      <= 1'b0;
         sv      <= 1'b0;
         ovf     <= 1'b0;
         cnt     <= '0;
      end else begin
         state <= next_state;
         Busy  <= (next_state == S_CHECK) || (next_state == S_DIV) || (next_state == S_FIX);
         Done  <= (next_state == S_DONE);
         case (state)
            S_IDLE: if (St) begin
               prem    <= {1'b0, dvd_abs[2*N-1:N]};
               qsr     <= dvd_abs[N-1:0];
               dvs_mag <= dvs_abs;
               sd      <= Dvd[2*N-1];
               sv      <= Dvs[N-1];
               ovf     <= 1'b0;
               V       <= 1'b0;
            end
            S_CHECK: begin
               ovf <= check_ovf;
               cnt <= '0;
            end
            S_DIV: begin
               prem <= trial_neg ? shifted : trial[N:0];
               qsr  <= {qsr[N-2:0], ~trial_neg};
               cnt  <= cnt + 1'b1;
            end
            S_FIX: begin
               V   <= fix_ovf;
               Quo <= fix_ovf ? '0 : q_fin[N-1:0];
               Rem <= fix_ovf ? '0 : r_fin;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_signed_divider_nbym.sv
// Directed-vector bench for signed_divider_nbym (N=16); honours DIV_EUCLID_EN for expectations.
module tb_signed_divider_nbym;

   logic        clk = 1'b0;
   logic        rst;
   logic        St;
   logic [31:0] Dvd;
   logic [15:0] Dvs;
   logic        Busy, Done, V;
   logic [15:0] Quo, Rem;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef DIV_EUCLID_EN
   localparam logic [15:0] Q_NP = 16'hFFF1, R_NP = 16'h0005;
   localparam logic [15:0] Q_NN = 16'h000F, R_NN = 16'h0005;
`else
   localparam logic [15:0] Q_NP = 16'hFFF2, R_NP = 16'hFFFE;
   localparam logic [15:0] Q_NN = 16'h000E, R_NN = 16'hFFFE;
`endif

   signed_divider_nbym #(.N(16)) dut (
      .clk (clk),
      .rst (rst),
      .St  (St),
      .Dvd (Dvd),
      .Dvs (Dvs),
      .Busy(Busy),
      .Done(Done),
      .V   (V),
      .Quo (Quo),
      .Rem (Rem)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Edge 1 is the load edge; latency is the edge after which Done is first seen.
   task automatic run_div(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                          input logic [15:0] eq, input logic [15:0] er, input logic ev,
                          input int elat, input int ebusy, input bit hold, input bit pulse);
      int edges;
      int busy_n;
      @(negedge clk);
      Dvd = dvd;
      Dvs = dvs;
      St  = 1'b1;
      @(posedge clk); #1;
      edges  = 1;
      busy_n = int'(Busy);
      if (!hold) St = 1'b0;
      Dvd = $urandom;
      Dvs = 16'($urandom);
      while (!Done && edges < 200) begin
         @(posedge clk); #1;
         edges++;
         busy_n += int'(Busy);
         if (pulse && edges == 6) St = 1'b1;
         if (pulse && edges == 7) St = 1'b0;
      end
      check({tag, "_lat"},  edges,  elat);
      check({tag, "_busy"}, busy_n, ebusy);
      check({tag, "_quo"},  Quo,    eq);
      check({tag, "_rem"},  Rem,    er);
      check({tag, "_v"},    V,      ev);
      if (!hold) begin
         @(posedge clk); #1;
         check({tag, "_idle"}, Done, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1;
      St  = 1'b0;
      Dvd = '0;
      Dvs = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", Busy, 1'b0);
      check("rst_done", Done, 1'b0);
      check("rst_v",    V,    1'b0);
      check("rst_quo",  Quo,  16'h0);
      check("rst_rem",  Rem,  16'h0);
      rst = 1'b0;

      run_div("p_p",   32'd100,       16'd7,     16'd14,   16'd2,    1'b0, 19, 18, 1'b0, 1'b0);
      run_div("n_p",   32'hFFFFFF9C,  16'd7,     Q_NP,     R_NP,     1'b0, 19, 18, 1'b0, 1'b0);
      run_div("p_n",   32'd100,       16'hFFF9,  16'hFFF2, 16'h0002, 1'b0, 19, 18, 1'b0, 1'b0);
      run_div("n_n",   32'hFFFFFF9C,  16'hFFF9,  Q_NN,     R_NN,     1'b0, 19, 18, 1'b0, 1'b0);
      run_div("dz",    32'd100,       16'd0,     16'h0,    16'h0,    1'b1, 3,  2,  1'b0, 1'b0);
      run_div("hi_ov", 32'h00010000,  16'd1,     16'h0,    16'h0,    1'b1, 3,  2,  1'b0, 1'b0);
      run_div("mn_m1", 32'h80000000,  16'hFFFF,  16'h0,    16'h0,    1'b1, 3,  2,  1'b0, 1'b0);
      run_div("rng_p", 32'd32768,     16'd1,     16'h0,    16'h0,    1'b1, 19, 18, 1'b0, 1'b0);
      run_div("rng_n", 32'hFFFF8000,  16'd1,     16'h8000, 16'h0,    1'b0, 19, 18, 1'b0, 1'b0);
      run_div("pulse", 32'd1000,      16'd33,    16'd30,   16'd10,   1'b0, 19, 18, 1'b0, 1'b1);

      // St held high through DONE keeps results stable until it drops.
      run_div("hold",  32'd100,       16'd7,     16'd14,   16'd2,    1'b0, 19, 18, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_done", Done, 1'b1);
         check("hold_quo",  Quo,  16'd14);
      end
      @(negedge clk);
      St = 1'b0;
      @(posedge clk); #1;
      check("drop_done", Done, 1'b0);
      check("drop_quo",  Quo,  16'd14);
      check("drop_rem",  Rem,  16'd2);

      // Reset on the 8th DIV cycle (the cycle ending at edge 10).
      @(negedge clk);
      Dvd = 32'd100;
      Dvs = 16'd7;
      St  = 1'b1;
      @(posedge clk); #1;
      St = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_busy", Busy, 1'b0);
      check("mid_rst_done", Done, 1'b0);
      check("mid_rst_v",    V,    1'b0);
      check("mid_rst_quo",  Quo,  16'h0);
      check("mid_rst_rem",  Rem,  16'h0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_done", Done, 1'b0);
      run_div("after_rst", 32'd100,   16'd7,     16'd14,   16'd2,    1'b0, 19, 18, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
